// File: rtl/fc_hwpe_ctrl_bridge.sv
// fc_hwpe_ctrl_bridge: APB slave to HWPE periph-port bridge with job tracking and event forwarding.
// Defining FC_HWPE_TIMEOUT_EN adds a REQ/RESP timeout that ends the access with pslverr.
module fc_hwpe_ctrl_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned N_EVT          = 4,
    parameter int unsigned N_EVT_OUT      = 2,
    parameter logic [7:0]  TRIGGER_OFFSET = 8'h00,
    parameter int unsigned JOB_CNT_W      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    input  logic                      pwrite,
    input  logic                      psel,
    input  logic                      penable,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      per_req_o,
    input  logic                      per_gnt_i,
    output logic [31:0]               per_add_o,
    output logic                      per_wen_o,
    output logic [3:0]                per_be_o,
    output logic [31:0]               per_data_o,
    output logic [ID_WIDTH-1:0]       per_id_o,
    input  logic [31:0]               per_r_data_i,
    input  logic                      per_r_valid_i,
    input  logic [ID_WIDTH-1:0]       per_r_id_i,
    input  logic [N_EVT-1:0]          evt_i,
    output logic [N_EVT_OUT-1:0]      evt_o,
    output logic                      busy_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [JOB_CNT_W-1:0] JOB_MAX = '1;

    logic [1:0]                state;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               data_q;
    logic [31:0]               prdata_q;
    logic                      wen_q;
    logic                      err_q;
    logic [ID_WIDTH-1:0]       id_q;
    logic [ID_WIDTH-1:0]       id_cnt;
    logic [JOB_CNT_W-1:0]      job_cnt;
    logic                      tmo_hit;
    logic                      trig;
    logic                      job_end;
    logic                      unused_evt;

`ifdef FC_HWPE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          waiting;
    assign waiting = state == REQ || state == RESP;
    assign tmo_hit = waiting && tmo_cnt >= TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (waiting)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            wen_q    <= 1'b0;
            id_q     <= '0;
            id_cnt   <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (psel && penable) begin
                state  <= REQ;
                addr_q <= paddr;
                data_q <= pwdata;
                wen_q  <= ~pwrite;
                id_q   <= id_cnt;
            end
        end else if (tmo_hit) begin
            state    <= DONE;
            prdata_q <= '0;
            err_q    <= 1'b1;
        end else if (state == REQ) begin
            if (per_gnt_i) begin
                state  <= RESP;
                id_cnt <= id_cnt + 1'b1;
            end
        end else if (state == RESP) begin
            if (per_r_valid_i) begin
                state    <= DONE;
                prdata_q <= wen_q ? per_r_data_i : '0;
                err_q    <= per_r_id_i != id_q;
            end
        end else begin
            state <= IDLE;
        end
    end

    // A trigger and a job end in the same cycle cancel out.
    assign trig    = state == REQ && per_gnt_i && !tmo_hit && !wen_q && addr_q[7:0] == TRIGGER_OFFSET;
    assign job_end = evt_i[0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            job_cnt <= '0;
            busy_o  <= 1'b0;
            evt_o   <= '0;
        end else begin
            if (trig && !job_end && job_cnt != JOB_MAX)
                job_cnt <= job_cnt + 1'b1;
            else if (job_end && !trig && job_cnt != '0)
                job_cnt <= job_cnt - 1'b1;
            busy_o <= job_cnt != '0;
            evt_o  <= evt_i[N_EVT_OUT-1:0];
        end
    end

    assign unused_evt = ^evt_i;
    assign per_req_o  = state == REQ;
    assign per_add_o  = 32'(addr_q);
    assign per_wen_o  = wen_q;
    assign per_be_o   = 4'hF;
    assign per_data_o = data_q;
    assign per_id_o   = id_q;
    assign pready     = state == DONE;
    assign pslverr    = err_q && state == DONE;
    assign prdata     = prdata_q;
endmodule

// File: tb/tb_fc_hwpe_ctrl_bridge.sv
// tb_fc_hwpe_ctrl_bridge: directed bench with a transaction-level model of the bridge.
module tb_fc_hwpe_ctrl_bridge;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        per_req_o;
    logic        per_gnt_i = 1'b0;
    logic [31:0] per_add_o;
    logic        per_wen_o;
    logic [3:0]  per_be_o;
    logic [31:0] per_data_o;
    logic [7:0]  per_id_o;
    logic [31:0] per_r_data_i = '0;
    logic        per_r_valid_i = 1'b0;
    logic [7:0]  per_r_id_i = '0;
    logic [3:0]  evt_i = '0;
    logic [1:0]  evt_o;
    logic        busy_o;

    fc_hwpe_ctrl_bridge dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .per_req_o(per_req_o), .per_gnt_i(per_gnt_i), .per_add_o(per_add_o),
        .per_wen_o(per_wen_o), .per_be_o(per_be_o), .per_data_o(per_data_o),
        .per_id_o(per_id_o), .per_r_data_i(per_r_data_i), .per_r_valid_i(per_r_valid_i),
        .per_r_id_i(per_r_id_i), .evt_i(evt_i), .evt_o(evt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          ready_cyc = 0;
    int          ready_cnt = 0;
    bit          chk_en = 0;
    bit          exp_req = 0;
    bit          exp_ready = 0;
    bit          exp_err = 0;
    bit          exp_wen = 0;
    bit          exp_busy = 0;
    bit          trig_now = 0;
    int          jobs = 0;
    logic [1:0]  exp_evt = '0;
    logic [31:0] exp_add = '0;
    logic [31:0] exp_data = '0;
    logic [31:0] exp_rdata = '0;
    logic [7:0]  exp_id = '0;
    logic [7:0]  cur_id = '0;
    logic [7:0]  last_id = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Job count and event forwarding expressed as counts of granted triggers and end pulses.
    always @(posedge clk) begin
        cyc++;
        if (!rst_ni) begin
            jobs = 0;
            exp_busy = 0;
            exp_evt = '0;
        end else begin
            exp_busy = jobs != 0;
            if (trig_now && !evt_i[0]) jobs = jobs < 3 ? jobs + 1 : 3;
            else if (evt_i[0] && !trig_now && jobs > 0) jobs = jobs - 1;
            exp_evt = evt_i[1:0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("per_req", 32'(per_req_o), 32'(exp_req));
            check("pready", 32'(pready), 32'(exp_ready));
            check("pslverr", 32'(pslverr), 32'(exp_err));
            check("busy", 32'(busy_o), 32'(exp_busy));
            check("evt_o", 32'(evt_o), 32'(exp_evt));
            check("per_be", 32'(per_be_o), 32'h0000_000F);
            if (exp_req) begin
                check("per_add", per_add_o, exp_add);
                check("per_wen", 32'(per_wen_o), 32'(exp_wen));
                check("per_data", per_data_o, exp_data);
                check("per_id", 32'(per_id_o), 32'(cur_id));
                last_id = per_id_o;
            end
            if (exp_ready) check("prdata", prdata, exp_rdata);
            if (pready) begin
                ready_cnt++;
                ready_cyc = cyc;
                last_rdata = prdata;
                last_err = pslverr;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input int gdly, input int rdly, input logic [31:0] rdat,
                            input logic [7:0] idx, input logic endg, input logic drop);
        paddr = a; pwdata = d; pwrite = w; psel = 1; penable = 0;
        tick;
        penable = 1; cur_id = exp_id; acc_cyc = cyc;
        tick;
        if (drop) begin psel = 0; penable = 0; end
        exp_req = 1; exp_add = a; exp_wen = ~w; exp_data = d;
        for (int k = 0; k <= gdly; k++) begin
            per_gnt_i = k == gdly;
            per_r_valid_i = k != gdly;
            per_r_data_i = 32'hDEAD_BEEF;
            trig_now = k == gdly && w && a[7:0] == 8'h00;
            evt_i[0] = k == gdly && endg;
            tick;
        end
        per_gnt_i = 0; trig_now = 0; evt_i[0] = 0; exp_req = 0; exp_id = exp_id + 8'd1;
        for (int k = 0; k <= rdly; k++) begin
            per_r_valid_i = k == rdly; per_r_data_i = rdat; per_r_id_i = cur_id ^ idx;
            tick;
        end
        per_r_valid_i = 0;
        exp_ready = 1; exp_err = idx != 0; exp_rdata = w ? 32'h0 : rdat;
        tick;
        exp_ready = 0; exp_err = 0; psel = 0; penable = 0;
    endtask

    task automatic evt_pulse(input logic [3:0] v);
        evt_i = v;
        tick;
        evt_i = '0;
        tick;
    endtask

    task automatic start_stuck;
        paddr = 32'h1A10_B000; pwdata = 32'h0000_0042; pwrite = 1; psel = 1; penable = 0;
        tick;
        penable = 1; cur_id = exp_id;
        tick;
        exp_req = 1; exp_add = 32'h1A10_B000; exp_wen = 0; exp_data = 32'h0000_0042;
    endtask

    initial begin
        int rc;
        tick;
        chk_en = 1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_add", per_add_o, 32'h0);
        check("rst_id", 32'(per_id_o), 32'h0);
        check("rst_wen", 32'(per_wen_o), 32'h0);
        check("rst_data", per_data_o, 32'h0);
        tick;
        rst_ni = 1;
        tick;
        apb_xfer(32'h1A10_B010, 32'h0, 0, 0, 0, 32'hCAFE_0001, 8'h00, 0, 0);
        check("t1_prdata", last_rdata, 32'hCAFE_0001);
        check("t1_pslverr", 32'(last_err), 32'h0);
        check("t1_latency", 32'(ready_cyc - acc_cyc), 32'd3);
        apb_xfer(32'h1A10_B000, 32'h0, 1, 3, 0, 32'h1234_5678, 8'h00, 0, 0);
        check("t2_busy_set", 32'(busy_o), 32'h1);
        evt_pulse(4'b0001);
        check("t2_busy_clr", 32'(busy_o), 32'h0);
        for (int i = 0; i < 4; i++)
            apb_xfer(32'h1A10_B000, 32'h100 + 32'(i), 1, i, i % 2, 32'h0, 8'h00, 0, 0);
        apb_xfer(32'h1A10_B004, 32'h5555_AAAA, 1, 0, 2, 32'h0, 8'h00, 0, 0);
        check("t3_busy_sat", 32'(busy_o), 32'h1);
        evt_pulse(4'b1011);
        evt_pulse(4'b0101);
        evt_pulse(4'b0011);
        check("t3_busy_drain", 32'(busy_o), 32'h0);
        evt_pulse(4'b1001);
        check("t3_busy_floor", 32'(busy_o), 32'h0);
        apb_xfer(32'h1A10_B000, 32'h1, 1, 1, 0, 32'h0, 8'h00, 0, 0);
        apb_xfer(32'h1A10_B000, 32'h2, 1, 0, 1, 32'h0, 8'h00, 1, 0);
        tick;
        check("t4_busy_hold", 32'(busy_o), 32'h1);
        evt_pulse(4'b0001);
        check("t4_busy_clr", 32'(busy_o), 32'h0);
        apb_xfer(32'h1A10_B0FC, 32'h0, 0, 2, 3, 32'h0BAD_F00D, 8'h00, 0, 1);
        check("drop_prdata", last_rdata, 32'h0BAD_F00D);
        apb_xfer(32'h1A10_B010, 32'h0, 0, 0, 0, 32'h7777_0000, 8'h01, 0, 0);
        check("t5_pslverr", 32'(last_err), 32'h1);
        while (exp_id != 8'hFF)
            apb_xfer(32'h1A10_B000 + {24'h0, exp_id}, 32'(exp_id), 0, 32'(exp_id) % 2, 32'(exp_id) % 3,
                     {exp_id, ~exp_id, exp_id, 8'h5A}, 8'h00, 0, 0);
        apb_xfer(32'h1A10_B020, 32'h0, 0, 0, 0, 32'h0000_00FF, 8'h00, 0, 0);
        check("t5_id_ff", 32'(last_id), 32'h0000_00FF);
        apb_xfer(32'h1A10_B024, 32'h0, 0, 0, 0, 32'h0000_0100, 8'h00, 0, 0);
        check("t5_id_wrap", 32'(last_id), 32'h0);
        start_stuck();
`ifdef FC_HWPE_TIMEOUT_EN
        repeat (255) tick;
        exp_req = 0; exp_ready = 1; exp_err = 1; exp_rdata = 32'h0;
        check("t6_tmo_ready", 32'(pready), 32'h1);
        check("t6_tmo_err", 32'(pslverr), 32'h1);
        tick;
        exp_ready = 0; exp_err = 0; psel = 0; penable = 0;
        per_r_valid_i = 1; per_r_data_i = 32'hFFFF_FFFF;
        tick;
        per_r_valid_i = 0;
        tick;
        check("t6_late_rvalid", 32'(pready), 32'h0);
        start_stuck();
        repeat (10) tick;
`else
        rc = ready_cnt;
        repeat (1000) tick;
        check("t6_no_ready", 32'(ready_cnt - rc), 32'h0);
`endif
        rst_ni = 0; psel = 0; penable = 0;
        tick;
        exp_req = 0; exp_id = '0;
        check("t6_rst_req", 32'(per_req_o), 32'h0);
        rst_ni = 1;
        tick;
        apb_xfer(32'h1A10_B014, 32'h0, 0, 0, 0, 32'hA5A5_0F0F, 8'h00, 0, 0);
        check("post_rst_id", 32'(last_id), 32'h0);
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
